alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Handshaked, width-parametrised sequential ALU: next generation of the team's combinational alu_v2.
- Keeps the alu_v2 opcode set; adds registered output with flags (Z/C/V/N), a persistent carry flag for multi-word add-with-carry, and a multi-cycle serial rotate.
- Sits between an operand-issuing controller and a result consumer; uses valid/ready on both sides.

Parameters:
- W, 8, operand/result width; power of two, >= 4.
- SW, $clog2(W), rotate-amount width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; transfer on in_valid && in_ready.
- op  in  3  opcode, sampled on transfer.
- a  in  W  operand A.
- b  in  W  operand B; for rotate, only b[SW-1:0] is used as the amount.
- ci  in  1  carry-in for op 001 only.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts; transfer on out_valid && out_ready.
- y  out  W  result.
- flag_z  out  1  y == 0.
- flag_c  out  1  carry flag (see below).
- flag_v  out  1  signed overflow.
- flag_n  out  1  y[W-1].

Behaviour:
- Reset (async assert, sync release):
  - y = 0; all flags = 0; out_valid = 0.
  - Stored carry c_q = 0; state = IDLE; rotate counter = 0.
  - in_ready = 1 in the first cycle after release.
- Opcodes, all W-bit arithmetic mod 2^W:
  - 000 pass: y = a.
  - 001 add: y = a + b + ci.
  - 010 sub: y = a + ~b + 1.
  - 011 adc: y = a + b + c_q.
  - 100 and.
  - 101 or.
  - 110 xor.
  - 111 rol: rotate a left by b[SW-1:0].
- Flags:
  - Z and N are computed from y for every op.
  - C for add/adc: carry out of bit W-1.
  - C for sub: carry out, i.e. 1 when a >= b unsigned.
  - C for rol: the bit rotated out on the final step (= y[0]); 0 if the amount is 0.
  - C for pass and logic ops: 0.
  - V for add/adc: a[W-1]==b[W-1] && y[W-1]!=a[W-1].
  - V for sub: a[W-1]!=b[W-1] && y[W-1]!=a[W-1].
  - V for all other ops: 0.
- c_q is loaded with flag_c whenever a result is produced (every op, including logic ops, which clear it).
- FSM states: IDLE, SHIFT.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - IDLE, transfer of op != 111, or op 111 with amount 0: result and flags registered at that edge; out_valid = 1 the next cycle (latency 1).
  - IDLE, transfer of op 111 with amount k > 0: latch a into a shift register and k into the counter; go to SHIFT.
  - SHIFT: rotate left by 1 per cycle, decrement counter. When the counter reaches 0, register the result and flags, set out_valid, return to IDLE.
  - Rotate latency is k+1 cycles from transfer to out_valid.
  - in_ready = 0 throughout SHIFT.
- Output register:
  - Holds y and flags stable while out_valid && !out_ready.
  - out_valid clears on output transfer unless a new result is loaded at the same edge.
  - Simultaneous output transfer and input transfer is legal and gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- in_valid while in_ready = 0: ignored; the source must hold it.
- Operand inputs are don't-care outside a transfer.
- rst_n asserted mid-SHIFT or with a pending result: everything returns to reset values immediately; the pending result is discarded.

Test Plan (W=8):
- Add: a=0xF0, b=0x20, ci=1, out_ready=1 -> next cycle out_valid=1, y=0x11, C=1, Z=0, V=0, N=0; c_q=1.
- Sub:
  - a=0x05, b=0x05 -> y=0x00, Z=1, C=1, V=0.
  - Then a=0x80, b=0x01 -> y=0x7F, C=1, V=1, N=0.
- Multi-word adc: add a=0xFF, b=0x01, ci=0 -> y=0x00, C=1; then adc a=0x01, b=0x01 -> y=0x03, C=0.
- Rotate: a=0x81, b=0x03 ->
  - in_ready=0 for 3 cycles; out_valid asserts 4 cycles after transfer.
  - y=0x0C, C=0.
  - Amount b=0x00 -> 1-cycle latency, y=a, C=0.
- Backpressure: issue xor a=0x0F, b=0xFF with out_ready=0 for 3 cycles -> y=0xF0, N=1 held stable, in_ready=0. Raising out_ready with in_valid high -> output and input transfers in the same cycle, next result 1 cycle later.
- Reset mid-rotate: drop rst_n 2 cycles into a rol by 7 -> out_valid=0, y=0, all flags=0 asynchronously. After release: in_ready=1, and adc a=0x01, b=0x01 gives y=0x02 (c_q cleared).

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result/flags, a persistent carry
// for multi-word add-with-carry, and a bit-serial left rotate.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_n
);

  localparam int SW = $clog2(W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        r_state;
  logic [W-1:0]  r_y;
  logic          r_z, r_c, r_v, r_n;
  logic          r_out_valid;
  logic          r_cq;
  logic [W-1:0]  r_sh;
  logic [SW-1:0] r_cnt;

  logic          w_in_fire, w_out_fire;
  logic [SW-1:0] w_amt;
  logic          w_start_rot;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_res;
  logic          w_c, w_v;
  logic [W-1:0]  w_rot_next;
  logic          w_rot_done;
  logic          w_load;
  logic [W-1:0]  w_load_y;
  logic          w_load_c, w_load_v;

  assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_amt      = b[SW-1:0];
  assign w_start_rot = w_in_fire && (op == 3'b111) && (w_amt != '0);

  assign w_rot_next = {r_sh[W-2:0], r_sh[W-1]};
  assign w_rot_done = (r_state == SHIFT) && (r_cnt == SW'(1));

  // Single-cycle datapath; a zero-amount rotate degenerates to pass.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      3'b000: w_res = a;
      3'b001: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (a[W-1] == b[W-1]) && (w_res[W-1] != a[W-1]);
      end
      3'b010: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (a[W-1] != b[W-1]) && (w_res[W-1] != a[W-1]);
      end
      3'b011: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, r_cq};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (a[W-1] == b[W-1]) && (w_res[W-1] != a[W-1]);
      end
      3'b100: w_res = a & b;
      3'b101: w_res = a | b;
      3'b110: w_res = a ^ b;
      default: w_res = a;
    endcase
  end

  // Result source: the immediate datapath in IDLE, the rotator on its last step.
  always_comb begin
    w_load   = 1'b0;
    w_load_y = w_res;
    w_load_c = w_c;
    w_load_v = w_v;
    if (r_state == SHIFT) begin
      w_load   = w_rot_done;
      w_load_y = w_rot_next;
      w_load_c = w_rot_next[0];
      w_load_v = 1'b0;
    end else begin
      w_load = w_in_fire && !w_start_rot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_y         <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_n         <= 1'b0;
      r_out_valid <= 1'b0;
      r_cq        <= 1'b0;
      r_sh        <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_rot) begin
            r_sh    <= a;
            r_cnt   <= w_amt;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh  <= w_rot_next;
          r_cnt <= r_cnt - SW'(1);
          if (w_rot_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_y         <= w_load_y;
        r_z         <= (w_load_y == '0);
        r_n         <= w_load_y[W-1];
        r_c         <= w_load_c;
        r_v         <= w_load_v;
        r_cq        <= w_load_c;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_n    = r_n;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8): directed vectors push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       ci;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       flag_z, flag_c, flag_v, flag_n;

  typedef struct packed {
    logic [7:0] y;
    logic       z, c, v, n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] ey, input logic ez, ec, ev, en);
    exp_t e;
    e.y = ey; e.z = ez; e.c = ec; e.v = ev; e.n = en;
    return e;
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t got;
      exp_t e;
      got = mk(y, flag_z, flag_c, flag_v, flag_n);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got y=0x%02h zcvn=%b%b%b%b expected none",
                 y, flag_z, flag_c, flag_v, flag_n);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL result: got y=0x%02h zcvn=%b%b%b%b expected y=0x%02h zcvn=%b%b%b%b",
                   got.y, got.z, got.c, got.v, got.n, e.y, e.z, e.c, e.v, e.n);
        end else begin
          $display("[%0t] out y=0x%02h zcvn=%b%b%b%b ok", $time,
                   got.y, got.z, got.c, got.v, got.n);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the input transfer.
  task automatic issue(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic cc);
    int n;
    in_valid = 1'b1; op = o; a = aa; b = bb; ci = cc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_y", {24'b0, y}, 32'h00);
    chk("rst_flags", {28'b0, flag_z, flag_c, flag_v, flag_n}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // add with carry-in, latency 1
    sb.push_back(mk(8'h11, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(3'b001, 8'hF0, 8'h20, 1'b1);
    chk("add_latency", {31'b0, out_valid}, 32'd1);
    // signed overflow on add
    sb.push_back(mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
    issue(3'b001, 8'h7F, 8'h01, 1'b0);
    // sub: equal, overflow, borrow
    sb.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    issue(3'b010, 8'h05, 8'h05, 1'b0);
    sb.push_back(mk(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0));
    issue(3'b010, 8'h80, 8'h01, 1'b0);
    sb.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(3'b010, 8'h01, 8'h02, 1'b0);
    // multi-word add chain
    sb.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    issue(3'b001, 8'hFF, 8'h01, 1'b0);
    sb.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(3'b011, 8'h01, 8'h01, 1'b0);
    // logic ops clear carry; adc afterwards sees c_q=0
    sb.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(3'b101, 8'h50, 8'h05, 1'b1);
    sb.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(3'b000, 8'h00, 8'hFF, 1'b1);
    sb.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(3'b011, 8'h01, 8'h01, 1'b1);

    // rotate by 3: three busy cycles, result in the fourth
    sb.push_back(mk(8'h0C, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(3'b111, 8'h81, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("rol3_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rol3_out_valid_early", {31'b0, out_valid}, 32'd0);
      tick();
    end
    chk("rol3_out_valid", {31'b0, out_valid}, 32'd1);
    // amount 0 (b=0x08 keeps only b[2:0]=0): pass-through, latency 1
    sb.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(3'b111, 8'hA5, 8'h08, 1'b0);
    chk("rol0_latency", {31'b0, out_valid}, 32'd1);
    // amount 1: MSB comes out as C
    sb.push_back(mk(8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(3'b111, 8'h80, 8'h01, 1'b0);
    chk("rol1_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rol1_out_valid", {31'b0, out_valid}, 32'd1);
    tick();

    // backpressure
    out_ready = 1'b0;
    sb.push_back(mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(3'b110, 8'h0F, 8'hFF, 1'b0);
    in_valid = 1'b1; op = 3'b100; a = 8'hF0; b = 8'h3C; ci = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_y_hold", {24'b0, y}, 32'hF0);
      chk("bp_n_hold", {31'b0, flag_n}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    sb.push_back(mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    in_valid = 1'b0;
    chk("bp_b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_b2b_y", {24'b0, y}, 32'h30);

    // reset in the middle of a rotate by 7, with c_q=1 beforehand
    sb.push_back(mk(8'h11, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(3'b001, 8'hF0, 8'h20, 1'b1);
    issue(3'b111, 8'h81, 8'h07, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_y", {24'b0, y}, 32'h00);
    chk("mid_rst_flags", {28'b0, flag_z, flag_c, flag_v, flag_n}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(3'b011, 8'h01, 8'h01, 1'b0);
    chk("post_rst_latency", {31'b0, out_valid}, 32'd1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
